// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone master bridge.
package wb_pkg;

  // Bridge FSM: idle, bus cycle in flight, response waiting for the client.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_mst_state_e;

  // Cycles of unanswered cyc/stb before the bridge forces an error.
  localparam int unsigned WB_TIMEOUT_DEFAULT = 255;

  // Number of byte lanes for a given data width.
  function automatic int unsigned wb_sel_w(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts cycles while enabled, flags the last allowed one.
// Ports:
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   clear               : restart the count at zero (wins over enable)
//   enable              : count this cycle
//   expired_c           : combinational, high when count == TIMEOUT-1 (never when TIMEOUT=0)
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic wb_clk_i,
  input  logic wb_rst_ni,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] cnt_q;

  // Saturating counter so a disabled timeout never wraps.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired_c = 1'b0;
    end else begin : g_timeout
      assign expired_c = (cnt_q == CW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: converts single valid/ready client requests
// into one Wishbone read/write cycle each and returns a valid/ready response.
// One transaction outstanding; all outputs registered.
// Ports:
//   wb_clk_i, wb_rst_ni              : clock, async active-low reset
//   req_valid_i/req_ready_o          : request handshake
//   req_we_i, req_adr_i, req_dat_i,
//   req_sel_i                        : request payload (sel==0 -> error, no bus cycle)
//   rsp_valid_o/rsp_ready_i          : response handshake
//   rsp_dat_o, rsp_err_o             : read data (0 on write/error), error flag
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_dat_o, wb_sel_o     : Wishbone initiator outputs
//   wb_dat_i, wb_ack_i, wb_err_i     : Wishbone read data and terminations
module wb_master_bridge
  import wb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = WB_TIMEOUT_DEFAULT
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [AW-1:0]   req_adr_i,
  input  logic [DW-1:0]   req_dat_i,
  input  logic [DW/8-1:0] req_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic            rsp_err_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i
);

  localparam int unsigned SEL_W = wb_sel_w(DW);

  wb_mst_state_e state_q, state_d;

  logic             ready_d;
  logic             cyc_d, stb_d, we_d;
  logic [AW-1:0]    adr_d;
  logic [DW-1:0]    dat_d;
  logic [SEL_W-1:0] sel_d;
  logic             rsp_valid_d, rsp_err_d;
  logic [DW-1:0]    rsp_dat_d;
  logic             cnt_clr, cnt_en, cnt_expired_c;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_ni (wb_rst_ni),
    .clear     (cnt_clr),
    .enable    (cnt_en),
    .expired_c (cnt_expired_c)
  );

  // State and output registers; reset drops any cycle in flight immediately.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      req_ready_o <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_o <= ready_d;
      wb_cyc_o    <= cyc_d;
      wb_stb_o    <= stb_d;
      wb_we_o     <= we_d;
      wb_adr_o    <= adr_d;
      wb_dat_o    <= dat_d;
      wb_sel_o    <= sel_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_err_o   <= rsp_err_d;
      rsp_dat_o   <= rsp_dat_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cyc_d       = wb_cyc_o;
    stb_d       = wb_stb_o;
    we_d        = wb_we_o;
    adr_d       = wb_adr_o;
    dat_d       = wb_dat_o;
    sel_d       = wb_sel_o;
    rsp_valid_d = rsp_valid_o;
    rsp_err_d   = rsp_err_o;
    rsp_dat_d   = rsp_dat_o;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          if (req_sel_i != '0) begin
            we_d    = req_we_i;
            adr_d   = req_adr_i;
            dat_d   = req_dat_i;
            sel_d   = req_sel_i;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            cnt_clr = 1'b1;
            state_d = BUS;
          end else begin
            // No byte lanes enabled: answer with an error without touching the bus.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_dat_d   = '0;
            state_d     = RESP;
          end
        end
      end

      BUS: begin
        cnt_en = 1'b1;
        if (wb_cyc_o && wb_stb_o) begin
          // err has priority over a simultaneous ack.
          if (wb_err_i || wb_ack_i || cnt_expired_c) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
            if (wb_err_i || !wb_ack_i) begin
              rsp_err_d = 1'b1;
              rsp_dat_d = '0;
            end else begin
              rsp_err_d = 1'b0;
              rsp_dat_d = wb_we_o ? '0 : wb_dat_i;
            end
          end
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_dat_d   = '0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

endmodule
